// File: rtl/coherence_pkg.sv
// Shared types for the snooping MSI cache node: line states, bus commands
// and the controller FSM encoding.
package coherence_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_M = 2'd2
    } line_state_e;

    typedef enum logic [1:0] {
        CMD_RD   = 2'd0,
        CMD_RDX  = 2'd1,
        CMD_UPGR = 2'd2,
        CMD_WB   = 2'd3
    } bus_cmd_e;

    typedef enum logic [2:0] {
        FSM_IDLE      = 3'd0,
        FSM_EVICT_REQ = 3'd1,
        FSM_EVICT_CMD = 3'd2,
        FSM_REQ       = 3'd3,
        FSM_CMD       = 3'd4,
        FSM_FILL      = 3'd5,
        FSM_DONE      = 3'd6
    } fsm_state_e;

endpackage

// File: rtl/snoop_line_store.sv
// Direct-mapped line array (state/tag/data). The snoop port updates line
// state first; the CPU port reads the post-snoop view and its write, when
// present, is applied on top of the snoop result.
module snoop_line_store
    import coherence_pkg::*;
#(
    parameter int LINES  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              snp_en,
    input  bus_cmd_e          snp_cmd,
    input  logic [IDX_W-1:0]  snp_index,
    input  logic [TAG_W-1:0]  snp_tag,
    input  logic [IDX_W-1:0]  rd_index,
    output line_state_e       rd_state,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  line_state_e       wr_state,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    output logic              snp_shared,
    output logic              snp_flush,
    output logic [DATA_W-1:0] snp_data
);

    line_state_e       state_q [LINES];
    line_state_e       post_state [LINES];
    line_state_e       state_d [LINES];
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [TAG_W-1:0]  tag_d [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [DATA_W-1:0] data_d [LINES];

    line_state_e       snp_line_state;
    logic              snp_match;
    logic              snp_shared_d, snp_shared_q;
    logic              snp_flush_d, snp_flush_q;
    logic [DATA_W-1:0] snp_data_d, snp_data_q;

    // Snoop lookup: response and the downgraded/invalidated line states.
    always_comb begin
        post_state     = state_q;
        snp_line_state = state_q[snp_index];
        snp_match      = snp_en && (snp_line_state != ST_I) && (tag_q[snp_index] == snp_tag);
        snp_shared_d   = snp_match;
        snp_flush_d    = snp_match && (snp_line_state == ST_M) &&
                         ((snp_cmd == CMD_RD) || (snp_cmd == CMD_RDX));
        snp_data_d     = snp_flush_d ? data_q[snp_index] : '0;
        if (snp_match) begin
            case (snp_cmd)
                CMD_RD:   if (snp_line_state == ST_M) post_state[snp_index] = ST_S;
                CMD_RDX:  post_state[snp_index] = ST_I;
                CMD_UPGR: post_state[snp_index] = ST_I;
                default:  ;
            endcase
        end
    end

    assign rd_state = post_state[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // CPU-side write lands on top of the post-snoop state.
    always_comb begin
        state_d = post_state;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            state_d[wr_index] = wr_state;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_data;
        end
    end

    // Line array and registered snoop response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                state_q[i] <= ST_I;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
            snp_shared_q <= 1'b0;
            snp_flush_q  <= 1'b0;
            snp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            snp_shared_q <= snp_shared_d;
            snp_flush_q  <= snp_flush_d;
            snp_data_q   <= snp_data_d;
        end
    end

    assign snp_shared = snp_shared_q;
    assign snp_flush  = snp_flush_q;
    assign snp_data   = snp_data_q;

endmodule

// File: rtl/snoop_cache_node.sv
// MSI snooping cache node: serves CPU requests, arbitrates for the bus on
// misses/upgrades, writes back dirty victims and answers other nodes' snoops.
// Bus handshake: bus_req is held from the request state until the cycle
// bus_gnt pulses (it is masked in that cycle); the command is driven for
// exactly one cycle, the cycle after the grant.
module snoop_cache_node
    import coherence_pkg::*;
#(
    parameter  int NODE_ID   = 0,
    parameter  int NUM_NODES = 4,
    parameter  int LINES     = 4,
    parameter  int TAG_W     = 5,
    parameter  int DATA_W    = 8,
    localparam int ID_W      = $clog2(NUM_NODES),
    localparam int IDX_W     = $clog2(LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_op,
    input  logic [IDX_W-1:0]  cpu_index,
    input  logic [TAG_W-1:0]  cpu_tag,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [1:0]        bus_cmd,
    output logic [IDX_W-1:0]  bus_index,
    output logic [TAG_W-1:0]  bus_tag,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              snoop_valid,
    input  logic [ID_W-1:0]   snoop_src,
    input  logic [1:0]        snoop_cmd,
    input  logic [IDX_W-1:0]  snoop_index,
    input  logic [TAG_W-1:0]  snoop_tag,
    output logic              snp_shared,
    output logic              snp_flush,
    output logic [DATA_W-1:0] snp_data,
    output logic [2:0]        dbg_state
);

    fsm_state_e        state_q, state_d;
    bus_cmd_e          cmd_q, cmd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, hit_d;

    line_state_e       rd_state;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    line_state_e       wr_state;
    logic [TAG_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_data;
    logic              line_hit;
    logic              snp_en;
    bus_cmd_e          snp_cmd;

    assign snp_cmd  = bus_cmd_e'(snoop_cmd);
    assign snp_en   = snoop_valid && (snoop_src != ID_W'(NODE_ID)) && (snp_cmd != CMD_WB);
    assign line_hit = (rd_state != ST_I) && (rd_tag == cpu_tag);

    snoop_line_store #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) u_store (
        .clock     (clock),
        .reset     (reset),
        .snp_en    (snp_en),
        .snp_cmd   (snp_cmd),
        .snp_index (snoop_index),
        .snp_tag   (snoop_tag),
        .rd_index  (cpu_index),
        .rd_state  (rd_state),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_index  (cpu_index),
        .wr_state  (wr_state),
        .wr_tag    (wr_tag),
        .wr_data   (wr_data),
        .snp_shared(snp_shared),
        .snp_flush (snp_flush),
        .snp_data  (snp_data)
    );

    // Controller state, pending command and the response captured for DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FSM_IDLE;
            cmd_q   <= CMD_RD;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state, line writes and bus/CPU outputs; CPU decisions use the post-snoop line.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rdata_d   = rdata_q;
        hit_d     = hit_q;
        wr_en     = 1'b0;
        wr_state  = rd_state;
        wr_tag    = cpu_tag;
        wr_data   = cpu_wdata;
        bus_req   = 1'b0;
        bus_cmd   = CMD_RD;
        bus_index = '0;
        bus_tag   = '0;
        bus_wdata = '0;
        cpu_ready = (state_q == FSM_DONE);
        cpu_hit   = (state_q == FSM_DONE) && hit_q;
        cpu_rdata = (state_q == FSM_DONE) ? rdata_q : '0;
        case (state_q)
            FSM_IDLE: begin
                if (cpu_req) begin
                    hit_d = 1'b0;
                    if (line_hit && !cpu_op) begin
                        rdata_d = rd_data;
                        hit_d   = 1'b1;
                        state_d = FSM_DONE;
                    end else if (line_hit && rd_state == ST_M) begin
                        wr_en    = 1'b1;
                        wr_state = ST_M;
                        rdata_d  = cpu_wdata;
                        hit_d    = 1'b1;
                        state_d  = FSM_DONE;
                    end else if (line_hit) begin
                        cmd_d   = CMD_UPGR;
                        state_d = FSM_REQ;
                    end else begin
                        cmd_d   = cpu_op ? CMD_RDX : CMD_RD;
                        state_d = (rd_state == ST_M) ? FSM_EVICT_REQ : FSM_REQ;
                    end
                end
            end
            FSM_EVICT_REQ: begin
                bus_req = !bus_gnt;
                if (bus_gnt) state_d = FSM_EVICT_CMD;
            end
            FSM_EVICT_CMD: begin
                bus_cmd   = CMD_WB;
                bus_index = cpu_index;
                bus_tag   = rd_tag;
                bus_wdata = rd_data;
                wr_en     = 1'b1;
                wr_state  = ST_I;
                wr_tag    = rd_tag;
                wr_data   = rd_data;
                state_d   = FSM_REQ;
            end
            FSM_REQ: begin
                bus_req = !bus_gnt;
                // A snoop that took our S copy away turns the upgrade into a full RdX.
                if (cmd_q == CMD_UPGR && !line_hit) cmd_d = CMD_RDX;
                if (bus_gnt) state_d = FSM_CMD;
            end
            FSM_CMD: begin
                bus_cmd   = cmd_q;
                bus_index = cpu_index;
                bus_tag   = cpu_tag;
                if (cmd_q == CMD_UPGR) begin
                    wr_en    = 1'b1;
                    wr_state = ST_M;
                    rdata_d  = cpu_wdata;
                    state_d  = FSM_DONE;
                end else begin
                    state_d = FSM_FILL;
                end
            end
            FSM_FILL: begin
                if (fill_valid) begin
                    wr_en = 1'b1;
                    if (cmd_q == CMD_RD) begin
                        wr_state = ST_S;
                        wr_data  = fill_data;
                        rdata_d  = fill_data;
                    end else begin
                        wr_state = ST_M;
                        rdata_d  = cpu_wdata;
                    end
                    state_d = FSM_DONE;
                end
            end
            FSM_DONE: state_d = FSM_IDLE;
            default:  state_d = FSM_IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_snoop_cache_node.sv
// Directed bench for snoop_cache_node (NODE_ID=0, 4 lines, 5-bit tag, 8-bit data).
module tb_snoop_cache_node;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_op = 1'b0;
    logic [1:0] cpu_index = '0;
    logic [4:0] cpu_tag = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ready;
    logic [7:0] cpu_rdata;
    logic       cpu_hit;
    logic       bus_req;
    logic       bus_gnt = 1'b0;
    logic [1:0] bus_cmd;
    logic [1:0] bus_index;
    logic [4:0] bus_tag;
    logic [7:0] bus_wdata;
    logic       fill_valid = 1'b0;
    logic [7:0] fill_data = '0;
    logic       snoop_valid = 1'b0;
    logic [1:0] snoop_src = '0;
    logic [1:0] snoop_cmd = '0;
    logic [1:0] snoop_index = '0;
    logic [4:0] snoop_tag = '0;
    logic       snp_shared;
    logic       snp_flush;
    logic [7:0] snp_data;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    snoop_cache_node #(
        .NODE_ID(0), .NUM_NODES(4), .LINES(4), .TAG_W(5), .DATA_W(8)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_index(cpu_index), .cpu_tag(cpu_tag),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_index(bus_index),
        .bus_tag(bus_tag), .bus_wdata(bus_wdata), .fill_valid(fill_valid), .fill_data(fill_data),
        .snoop_valid(snoop_valid), .snoop_src(snoop_src), .snoop_cmd(snoop_cmd),
        .snoop_index(snoop_index), .snoop_tag(snoop_tag),
        .snp_shared(snp_shared), .snp_flush(snp_flush), .snp_data(snp_data),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Miss on an invalid or clean line: REQ, immediate grant, CMD, FILL, DONE.
    task automatic miss_txn(input logic op, input logic [1:0] idx, input logic [4:0] tg,
                            input logic [7:0] wd, input logic [7:0] fd,
                            input logic [1:0] exp_cmd, input string nm);
        cpu_req = 1'b1; cpu_op = op; cpu_index = idx; cpu_tag = tg; cpu_wdata = wd;
        tick();
        chk({nm, "_bus_req"}, bus_req, 1);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        chk({nm, "_bus_cmd"}, bus_cmd, exp_cmd);
        chk({nm, "_bus_tag"}, bus_tag, tg);
        tick();
        fill_valid = 1'b1; fill_data = fd;
        tick();
        fill_valid = 1'b0;
        chk({nm, "_ready"}, cpu_ready, 1);
        chk({nm, "_hit"}, cpu_hit, 0);
        if (op == 1'b0) chk({nm, "_rdata"}, cpu_rdata, fd);
        cpu_req = 1'b0;
        tick();
    endtask

    // Read that must hit: ready one cycle after the request is sampled.
    task automatic hit_read(input logic [1:0] idx, input logic [4:0] tg,
                            input logic [7:0] exp_data, input string nm);
        cpu_req = 1'b1; cpu_op = 1'b0; cpu_index = idx; cpu_tag = tg;
        tick();
        chk({nm, "_ready"}, cpu_ready, 1);
        chk({nm, "_hit"}, cpu_hit, 1);
        chk({nm, "_rdata"}, cpu_rdata, exp_data);
        chk({nm, "_bus_req"}, bus_req, 0);
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic snoop(input logic [1:0] src, input logic [1:0] cmd,
                         input logic [1:0] idx, input logic [4:0] tg);
        snoop_valid = 1'b1; snoop_src = src; snoop_cmd = cmd; snoop_index = idx; snoop_tag = tg;
        tick();
        snoop_valid = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_ready", cpu_ready, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_snp_shared", snp_shared, 0);
        chk("rst_snp_flush", snp_flush, 0);
        chk("rst_snp_data", snp_data, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;
        tick();

        // line 2: S, tag 14, data 50; then read hit
        miss_txn(1'b0, 2'd2, 5'd14, 8'd0, 8'd50, 2'd0, "rd_miss");
        hit_read(2'd2, 5'd14, 8'd50, "rd_hit");

        // line 1: M, tag 12, data 40
        miss_txn(1'b1, 2'd1, 5'd12, 8'd40, 8'hAA, 2'd1, "wr_miss");

        // write miss with dirty victim: WB(12,40), then RDX(3)
        cpu_req = 1'b1; cpu_op = 1'b1; cpu_index = 2'd1; cpu_tag = 5'd3; cpu_wdata = 8'h77;
        tick();
        chk("ev_state", dbg_state, 1);
        chk("ev_bus_req", bus_req, 1);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        chk("ev_cmd", bus_cmd, 3);
        chk("ev_index", bus_index, 1);
        chk("ev_tag", bus_tag, 12);
        chk("ev_wdata", bus_wdata, 40);
        tick();
        chk("ev_req_state", dbg_state, 3);
        chk("ev_req_bus_req", bus_req, 1);
        tick();
        chk("ev_req_hold", bus_req, 1);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        chk("ev_rdx_cmd", bus_cmd, 1);
        chk("ev_rdx_tag", bus_tag, 3);
        tick();
        fill_valid = 1'b1; fill_data = 8'h55;
        tick();
        fill_valid = 1'b0;
        chk("ev_ready", cpu_ready, 1);
        chk("ev_hit", cpu_hit, 0);
        cpu_req = 1'b0;
        tick();
        hit_read(2'd1, 5'd3, 8'h77, "ev_line");

        // snoop flush: line 0 M data 30, RD from node 2
        miss_txn(1'b1, 2'd0, 5'd7, 8'd30, 8'hEE, 2'd1, "wr_l0");
        snoop(2'd2, 2'd0, 2'd0, 5'd7);
        chk("fl_flush", snp_flush, 1);
        chk("fl_shared", snp_shared, 1);
        chk("fl_data", snp_data, 30);
        tick();
        chk("fl_pulse", snp_flush, 0);

        // upgrade race: write hit on S, snoop UPGR while in REQ -> RDX
        cpu_req = 1'b1; cpu_op = 1'b1; cpu_index = 2'd0; cpu_tag = 5'd7; cpu_wdata = 8'h99;
        tick();
        chk("up_state", dbg_state, 3);
        snoop(2'd3, 2'd2, 2'd0, 5'd7);
        chk("up_snp_shared", snp_shared, 1);
        chk("up_snp_flush", snp_flush, 0);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        chk("up_cmd", bus_cmd, 1);
        chk("up_tag", bus_tag, 7);
        tick();
        chk("up_fill_state", dbg_state, 5);
        fill_valid = 1'b1; fill_data = 8'h11;
        tick();
        fill_valid = 1'b0;
        chk("up_ready", cpu_ready, 1);
        chk("up_hit", cpu_hit, 0);
        cpu_req = 1'b0;
        tick();
        hit_read(2'd0, 5'd7, 8'h99, "up_line");

        // own snoop ignored
        snoop(2'd0, 2'd1, 2'd2, 5'd14);
        chk("own_shared", snp_shared, 0);
        chk("own_flush", snp_flush, 0);
        hit_read(2'd2, 5'd14, 8'd50, "own_line");

        // RDX from node 1 invalidates S line 2
        snoop(2'd1, 2'd1, 2'd2, 5'd14);
        chk("rdx_shared", snp_shared, 1);
        chk("rdx_flush", snp_flush, 0);

        // read now misses; reset in FILL
        cpu_req = 1'b1; cpu_op = 1'b0; cpu_index = 2'd2; cpu_tag = 5'd14;
        tick();
        chk("inv_miss_state", dbg_state, 3);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        chk("inv_cmd", bus_cmd, 0);
        tick();
        chk("rf_state", dbg_state, 5);
        #2;
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("rf_state0", dbg_state, 0);
        chk("rf_bus_req", bus_req, 0);
        chk("rf_ready", cpu_ready, 0);
        chk("rf_snp_shared", snp_shared, 0);
        tick();
        reset = 1'b0;
        tick();

        // previously M line 1 now misses
        cpu_req = 1'b1; cpu_op = 1'b0; cpu_index = 2'd1; cpu_tag = 5'd3;
        tick();
        chk("post_rst_state", dbg_state, 3);
        chk("post_rst_ready", cpu_ready, 0);
        chk("post_rst_bus_req", bus_req, 1);
        cpu_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
